// File: rtl/viterbi_decode_param.sv
// Rate-1/2 hard-decision Viterbi decoder with per-bit erasures and register-exchange survivors.
// One symbol is consumed per accepting clock; the decoded bit emerges TB_DEPTH-1 symbols later.
module viterbi_decode_param #(
  parameter int             K        = 3,
  parameter logic [K-1:0]   G0       = 3'b111,
  parameter logic [K-1:0]   G1       = 3'b101,
  parameter int             TB_DEPTH = 15,
  parameter int             METRIC_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] data_in,
  input  logic [1:0] in_era,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       data_out,
  output logic       out_valid
);

  localparam int NS = 1 << (K - 1);
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [METRIC_W-1:0] PM_MAX  = {METRIC_W{1'b1}};
  localparam logic [METRIC_W-1:0] PM_INIT = {1'b1, {(METRIC_W-1){1'b0}}};
  localparam logic [CW-1:0]       CNT_MAX = CW'(TB_DEPTH);

  logic [METRIC_W-1:0] r_pm   [NS];
  logic [TB_DEPTH-1:0] r_surv [NS];
  logic [CW-1:0]       r_cnt;
  logic                r_data_out;
  logic                r_out_valid;

  logic [METRIC_W-1:0] w_pm_old   [NS];
  logic [TB_DEPTH-1:0] w_surv_old [NS];
  logic [METRIC_W-1:0] w_pm_acs   [NS];
  logic [METRIC_W-1:0] w_pm_new   [NS];
  logic [TB_DEPTH-1:0] w_surv_new [NS];
  logic [METRIC_W-1:0] w_pm_min;
  logic [K-2:0]        w_best;
  logic [K-2:0]        w_n;
  logic [K-2:0]        w_p0;
  logic [K-2:0]        w_p1;
  logic [METRIC_W-1:0] w_m0;
  logic [METRIC_W-1:0] w_m1;
  logic [CW-1:0]       w_cnt_next;

  // Hamming distance to the branch label; erased bits never count as errors.
  function automatic logic [1:0] bm_calc(input logic [K-1:0] enc, input logic [1:0] sym,
                                         input logic [1:0] era);
    logic c0;
    logic c1;
    c0 = ^(G0 & enc);
    c1 = ^(G1 & enc);
    return {1'b0, (!era[1] && (sym[1] != c0))} + {1'b0, (!era[0] && (sym[0] != c1))};
  endfunction

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [1:0] b);
    logic [METRIC_W:0] s;
    s = {1'b0, a} + {{(METRIC_W-1){1'b0}}, b};
    if (s > {1'b0, PM_MAX}) begin
      return PM_MAX;
    end else begin
      return s[METRIC_W-1:0];
    end
  endfunction

  // Start of frame replaces stored history with the known-zero starting state.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      if (in_sof) begin
        w_pm_old[s]   = (s == 0) ? {METRIC_W{1'b0}} : PM_INIT;
        w_surv_old[s] = {TB_DEPTH{1'b0}};
      end else begin
        w_pm_old[s]   = r_pm[s];
        w_surv_old[s] = r_surv[s];
      end
    end
  end

  // Add-compare-select, then best-state search and normalisation.
  always_comb begin
    w_n  = {(K-1){1'b0}};
    w_p0 = {(K-1){1'b0}};
    w_p1 = {(K-1){1'b0}};
    w_m0 = {METRIC_W{1'b0}};
    w_m1 = {METRIC_W{1'b0}};
    for (int n = 0; n < NS; n++) begin
      w_n  = (K-1)'(n);
      w_p0 = {w_n[K-3:0], 1'b0};
      w_p1 = {w_n[K-3:0], 1'b1};
      w_m0 = sat_add(w_pm_old[w_p0], bm_calc({w_n[K-2], w_p0}, data_in, in_era));
      w_m1 = sat_add(w_pm_old[w_p1], bm_calc({w_n[K-2], w_p1}, data_in, in_era));
      // Strict compare: a tie keeps the predecessor whose appended bit is 0.
      if (w_m1 < w_m0) begin
        w_pm_acs[n]   = w_m1;
        w_surv_new[n] = (w_surv_old[w_p1] << 1) | {{(TB_DEPTH-1){1'b0}}, w_n[K-2]};
      end else begin
        w_pm_acs[n]   = w_m0;
        w_surv_new[n] = (w_surv_old[w_p0] << 1) | {{(TB_DEPTH-1){1'b0}}, w_n[K-2]};
      end
    end
    w_pm_min = w_pm_acs[0];
    w_best   = {(K-1){1'b0}};
    for (int n = 1; n < NS; n++) begin
      w_best   = (w_pm_acs[n] < w_pm_min) ? (K-1)'(n) : w_best;
      w_pm_min = (w_pm_acs[n] < w_pm_min) ? w_pm_acs[n] : w_pm_min;
    end
    for (int n = 0; n < NS; n++) begin
      w_pm_new[n] = w_pm_acs[n] - w_pm_min;
    end
  end

  // Accepted-symbol counter saturates at TB_DEPTH; start of frame counts as the first symbol.
  always_comb begin
    if (in_sof) begin
      w_cnt_next = {{(CW-1){1'b0}}, 1'b1};
    end else if (r_cnt >= CNT_MAX) begin
      w_cnt_next = CNT_MAX;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Metric, survivor, counter and output registers; idle cycles hold everything but out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        r_pm[s]   <= (s == 0) ? {METRIC_W{1'b0}} : PM_INIT;
        r_surv[s] <= {TB_DEPTH{1'b0}};
      end
      r_cnt       <= {CW{1'b0}};
      r_data_out  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      for (int s = 0; s < NS; s++) begin
        r_pm[s]   <= w_pm_new[s];
        r_surv[s] <= w_surv_new[s];
      end
      r_cnt       <= w_cnt_next;
      r_data_out  <= w_surv_new[w_best][TB_DEPTH-1];
      r_out_valid <= (w_cnt_next == CNT_MAX);
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_viterbi_decode_param.sv
// Self-checking bench for viterbi_decode_param with TB_DEPTH=5: reference frame table plus
// restart, reset, gap and long-run sequences, checked through an expected-bit scoreboard.
module tb_viterbi_decode_param;

  localparam int TBD = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] data_in = 2'b00;
  logic [1:0] in_era = 2'b00;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       data_out;
  logic       out_valid;

  always #5 clk = ~clk;

  viterbi_decode_param #(
    .K(3), .G0(3'b111), .G1(3'b101), .TB_DEPTH(TBD), .METRIC_W(6)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_era(in_era),
    .in_valid(in_valid), .in_sof(in_sof), .data_out(data_out), .out_valid(out_valid)
  );

  typedef struct {
    logic [1:0] sym;
    logic [1:0] era;
    logic       ev;
    logic       eb;
  } vec_t;

  vec_t vecs [10];
  logic sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic last_known = 1'b0;
  logic last_bit   = 1'b0;

  task automatic step(input logic [1:0] sym, input logic [1:0] era, input logic sof,
                      input logic ev, input logic eb, input string tag);
    logic exp_b;
    data_in = sym; in_era = era; in_sof = sof; in_valid = 1'b1;
    if (ev) sb_q.push_back(eb);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_era = 2'b00;
    n_tests++;
    if (out_valid !== ev) begin
      n_fail++;
      $display("FAIL %s out_valid: got %b want %b", tag, out_valid, ev);
      if (ev && sb_q.size() > 0) exp_b = sb_q.pop_front();
    end
    if (out_valid === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s scoreboard: unexpected output %b, nothing expected", tag, data_out);
      end else begin
        exp_b = sb_q.pop_front();
        if (data_out !== exp_b) begin
          n_fail++;
          $display("FAIL %s data_out: got %b want %b", tag, data_out, exp_b);
        end
      end
    end
    last_known = ev;
    last_bit   = eb;
  endtask

  task automatic idle(input int n, input logic sof, input string tag);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0; in_sof = sof; data_in = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle out_valid: got %b want 0", tag, out_valid);
      end
      if (last_known) begin
        n_tests++;
        if (data_out !== last_bit) begin
          n_fail++;
          $display("FAIL %s idle hold data_out: got %b want %b", tag, data_out, last_bit);
        end
      end
    end
    in_sof = 1'b0;
  endtask

  task automatic do_reset(input logic with_valid, input string tag);
    rst = 1'b1; in_valid = with_valid; in_sof = with_valid; data_in = 2'b11; in_era = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    n_tests += 2;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reset out_valid: got %b want 0", tag, out_valid);
    end
    if (data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reset data_out: got %b want 0", tag, data_out);
    end
    last_known = 1'b1;
    last_bit   = 1'b0;
  endtask

  // variant: 0 clean, 1 bit error on symbol 2, 2 c1 erased on symbols 2 and 4, 3 symbol 2 fully erased
  task automatic run_frame(input int variant, input logic first_sof, input logic gaps,
                           input string tag);
    logic [1:0] s;
    logic [1:0] e;
    for (int k = 0; k < 10; k++) begin
      s = vecs[k].sym;
      e = vecs[k].era;
      if (variant == 1 && k == 1) s = 2'b11;
      if (variant == 2 && (k == 1 || k == 3)) e = 2'b01;
      if (variant == 3 && k == 1) e = 2'b11;
      step(s, e, (k == 0) ? first_sof : 1'b0, vecs[k].ev, vecs[k].eb, tag);
      if (gaps) idle(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), tag);
    end
  endtask

  initial begin
    // Encoded 1,0,1,1,0,0,0,0,0,0 with G0=111, G1=101; first bit out after the 5th symbol.
    vecs[0] = '{2'b11, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{2'b00, 2'b00, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 2'b00, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 2'b00, 1'b1, 1'b1};
    vecs[5] = '{2'b11, 2'b00, 1'b1, 1'b0};
    vecs[6] = '{2'b00, 2'b00, 1'b1, 1'b1};
    vecs[7] = '{2'b00, 2'b00, 1'b1, 1'b1};
    vecs[8] = '{2'b00, 2'b00, 1'b1, 1'b0};
    vecs[9] = '{2'b00, 2'b00, 1'b1, 1'b0};

    do_reset(1'b0, "rst0");
    do_reset(1'b0, "rst1");

    run_frame(0, 1'b0, 1'b0, "clean");
    run_frame(1, 1'b1, 1'b0, "err");
    run_frame(2, 1'b1, 1'b0, "era");
    run_frame(3, 1'b1, 1'b0, "era2");
    run_frame(0, 1'b1, 1'b1, "gaps");

    // Frame cut short after 3 symbols by a new start of frame.
    step(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "pre_sof");
    step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "pre_sof");
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "pre_sof");
    run_frame(0, 1'b1, 1'b0, "sof_restart");

    // Frame cut short after 3 symbols by reset asserted together with a valid sof symbol.
    step(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "pre_rst");
    step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "pre_rst");
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "pre_rst");
    do_reset(1'b1, "rst_mid");
    run_frame(0, 1'b0, 1'b0, "rst_restart");

    // Long all-zero run: counter saturates, every output is 0.
    do_reset(1'b0, "rst_sat");
    for (int k = 0; k < 1000; k++) begin
      step(2'b00, 2'b00, 1'b0, (k >= TBD - 1) ? 1'b1 : 1'b0, 1'b0, "sat");
    end

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain scoreboard: %0d entries left, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_decode_param.md
VITERBI_DECODE_PARAM -- requirements
Module: viterbi_decode_param

Interface
REQ-001 The block SHALL have parameter K, default 3, meaning the constraint length, legal range 3..7.
REQ-002 The block SHALL have parameter G0, default 3'b111, meaning the generator for code bit c0, K bits wide, MSB applied to the newest input bit.
REQ-003 The block SHALL have parameter G1, default 3'b101, meaning the generator for code bit c1, with the same format as G0.
REQ-004 The block SHALL have parameter TB_DEPTH, default 15, meaning the survivor length in symbols, legal range 4..64.
REQ-005 The block SHALL have parameter METRIC_W, default 6, meaning the path-metric width, with METRIC_W >= 4.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port data_in, input, 2 bits: hard-decision symbol, [1]=c0 and [0]=c1.
REQ-009 The block SHALL have port in_era, input, 2 bits: per-bit erasure, 1 = bit punctured or unknown.
REQ-010 The block SHALL have port in_valid, input, 1 bit: symbol accepted on every clk edge where in_valid=1; there is no backpressure.
REQ-011 The block SHALL have port in_sof, input, 1 bit: start of frame, qualified by in_valid.
REQ-012 The block SHALL have port data_out, output, 1 bit: decoded information bit.
REQ-013 The block SHALL have port out_valid, output, 1 bit: data_out is valid this cycle.

Function
REQ-014 Encoder model: state s is {u[t-1]..u[t-K+1]}, with u[t-1] as MSB; c0=XOR(G0 & {u[t],s}); c1=XOR(G1 & {u[t],s}); next state is {u[t], s[K-2:1]}.
REQ-015 Branch metric: Hamming distance between data_in and the expected {c0,c1}; an erased bit contributes 0; range 0..2.
REQ-016 ACS: for each next state n, the predecessors are {n[K-3:0],0} and {n[K-3:0],1}; the block SHALL select the smaller PM+BM; on a tie it SHALL select the predecessor with appended bit 0.
REQ-017 Adds SHALL saturate at 2^METRIC_W-1.
REQ-018 Normalisation: after ACS, the minimum new metric SHALL be subtracted from all 2^(K-1) metrics in the same cycle, so that the minimum stored metric is always 0.
REQ-019 Survivors: register-exchange, one TB_DEPTH-bit register per state; survivor(n) = {survivor(pred)[TB_DEPTH-2:0], n[K-2]}.
REQ-020 Best state: the lowest-index state with the minimum new metric.
REQ-021 Output: on an accepting edge, data_out SHALL load survivor(best)[TB_DEPTH-1] of the updated survivors.
REQ-022 Output valid: out_valid=1 for exactly one cycle after the accepting edge when the accepted-symbol count (including the current symbol) is >= TB_DEPTH; otherwise out_valid=0.
REQ-023 Latency: the decoded bit for symbol j SHALL appear in the cycle after symbol j+TB_DEPTH-1 is accepted.
REQ-024 Symbol counter: SHALL saturate at TB_DEPTH and never wrap.
REQ-025 Idle cycles (in_valid=0): metrics, survivors and counter SHALL hold; out_valid=0; data_out SHALL hold its last value.
REQ-026 in_sof=1 with in_valid=1: ACS SHALL use the initial metrics (state 0 = 0, all others = 2^(METRIC_W-1)) in place of the stored metrics, and the symbol SHALL be counted as count 1.
REQ-027 in_sof mid-stream: bits of the previous frame still in survivors SHALL be discarded; out_valid SHALL stay low until TB_DEPTH symbols of the new frame have been accepted.
REQ-028 in_sof=1 with in_valid=0 SHALL be ignored.
REQ-029 Both bits erased: BM SHALL be 0 for all branches; ACS, including tie rules, SHALL still execute and the symbol SHALL be counted.

Reset
REQ-030 When rst=1 on a clk edge, the block SHALL set state 0 metric = 0, all other metrics = 2^(METRIC_W-1), all survivors = 0, count = 0, data_out = 0 and out_valid = 0.
REQ-031 rst SHALL take priority over in_valid and in_sof in the same cycle.
REQ-032 Reset mid-frame SHALL discard all pending bits; no out_valid SHALL occur until TB_DEPTH new symbols have been accepted.

Verification
REQ-033 Scenario, clean decode: with TB_DEPTH=5 and defaults, after rst, feed 11,10,00,01,01,11 then 00 repeated (in_valid=1 continuously) -> the first out_valid occurs after the 5th symbol, and data_out = 1,0,1,1,0,0,0...
REQ-034 Scenario, single error: repeat the clean-decode stimulus with the 2nd symbol changed from 10 to 11 -> the decoded sequence SHALL be identical.
REQ-035 Scenario, erasure: repeat the clean-decode stimulus with in_era=2'b01 on symbols 2 and 4 -> the decoded sequence SHALL be identical.
REQ-036 Scenario, gaps: insert in_valid=0 gaps of 1-3 cycles between symbols -> the same bit sequence SHALL be produced, out_valid pulses SHALL only follow accepting edges, and data_out SHALL hold during gaps.
REQ-037 Scenario, saturation: feed 1000 symbols of 00 -> all outputs SHALL be 0, the state 0 metric SHALL stay 0, and no metric SHALL exceed 2^METRIC_W-1.
REQ-038 Scenario, restart: assert in_sof after 3 symbols of one frame, and separately assert rst after 3 symbols -> no out_valid SHALL occur for the next 4 accepted symbols, and the new frame SHALL decode as in REQ-033.
